// File: rtl/apb_ucpd_tx_seq.sv
// Purpose: USB-PD transmit phase sequencer (preamble, ordered set, data, CRC, EOP, BIST, inter-frame gap).
// Latency: phase transitions and pulses register on the ic_clk edge that consumes the final bit_tick of a phase.
// Backpressure: txdr_vld low at a byte load point is an underrun: the load is skipped, tx_abort pulses, EOP follows.
//
// Ports:
//   ic_clk, ic_rst_n          clock, asynchronous active-low reset
//   ucpden                    block enable, low = synchronous clear to IDLE
//   bit_tick                  one strobe per transmitted bit
//   tx_req/tx_mode            start request and frame type (0 msg, 1 hard rst, 2 cable rst, 3 BIST)
//   tx_paysize/bist_len/ifg_bits  frame geometry, captured when leaving IDLE
//   txdr_vld/txdr_req/txfifo_ld   TX byte handshake
//   tx_state, *_en, bmc_en, busy  state and phase decodes
//   tx_done, tx_abort         one-cycle completion / underrun pulses
module apb_ucpd_tx_seq #(
    parameter int PRE_BITS = 64,
    parameter int SOP_BITS = 20,
    parameter int CRC_BITS = 40,
    parameter int EOP_BITS = 5,
    parameter int PAY_W    = 10,
    parameter int IFG_W    = 8
) (
    input  logic             ic_clk,
    input  logic             ic_rst_n,
    input  logic             ucpden,
    input  logic             bit_tick,
    input  logic             tx_req,
    input  logic [1:0]       tx_mode,
    input  logic [PAY_W-1:0] tx_paysize,
    input  logic [15:0]      bist_len,
    input  logic [IFG_W-1:0] ifg_bits,
    input  logic             txdr_vld,
    output logic             txdr_req,
    output logic             txfifo_ld,
    output logic [2:0]       tx_state,
    output logic             pre_en,
    output logic             sop_en,
    output logic             data_en,
    output logic             crc_en,
    output logic             eop_en,
    output logic             bist_en,
    output logic             wait_en,
    output logic             bmc_en,
    output logic             busy,
    output logic             tx_done,
    output logic             tx_abort
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SOP  = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4,
        ST_EOP  = 3'd5,
        ST_BIST = 3'd6,
        ST_WAIT = 3'd7
    } state_t;

    localparam logic [PAY_W-1:0] PAY_ONE = {{(PAY_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [15:0]      bit_cnt;     // ticks consumed in the current phase
    logic [3:0]       byte_bit;    // tick position inside the current data byte
    logic [PAY_W-1:0] byte_cnt;    // index of the byte being sent
    logic [PAY_W-1:0] load_cnt;    // bytes pulled from the TX FIFO this frame
    logic [PAY_W-1:0] pay_q;       // captured payload size, never 0
    logic [1:0]       mode_q;
    logic [15:0]      bist_q;      // captured BIST length, never 0
    logic [IFG_W-1:0] ifg_q;
    logic             aborted;     // an underrun happened in this frame

    logic [15:0]      last_cnt;
    logic             phase_end;
    logic             last_byte;

    // Final bit_cnt value of each fixed/captured-length phase. WAIT lasts
    // ifg+1 ticks, so its terminal count is ifg itself.
    always_comb begin
        last_cnt = '0;
        case (state)
            ST_PRE:  last_cnt = 16'(PRE_BITS - 1);
            ST_SOP:  last_cnt = 16'(SOP_BITS - 1);
            ST_CRC:  last_cnt = 16'(CRC_BITS - 1);
            ST_EOP:  last_cnt = 16'(EOP_BITS - 1);
            ST_BIST: last_cnt = bist_q - 16'd1;
            ST_WAIT: last_cnt = 16'(ifg_q);
            default: last_cnt = '0;
        endcase
    end

    assign phase_end = bit_tick & (bit_cnt == last_cnt);
    assign last_byte = (byte_cnt == (pay_q - PAY_ONE));

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            byte_bit  <= '0;
            byte_cnt  <= '0;
            load_cnt  <= '0;
            pay_q     <= PAY_ONE;
            mode_q    <= '0;
            bist_q    <= 16'd1;
            ifg_q     <= '0;
            aborted   <= 1'b0;
            txfifo_ld <= 1'b0;
            tx_done   <= 1'b0;
            tx_abort  <= 1'b0;
        end else if (!ucpden) begin
            // Disable wins over any phase end, load or completion this cycle.
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            byte_bit  <= '0;
            byte_cnt  <= '0;
            load_cnt  <= '0;
            aborted   <= 1'b0;
            txfifo_ld <= 1'b0;
            tx_done   <= 1'b0;
            tx_abort  <= 1'b0;
        end else begin
            txfifo_ld <= 1'b0;
            tx_done   <= 1'b0;
            tx_abort  <= 1'b0;
            if (bit_tick) begin
                bit_cnt <= bit_cnt + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (tx_req && bit_tick) begin
                        pay_q    <= (tx_paysize == '0) ? PAY_ONE : tx_paysize;
                        bist_q   <= (bist_len == 16'd0) ? 16'd1 : bist_len;
                        ifg_q    <= ifg_bits;
                        mode_q   <= tx_mode;
                        byte_bit <= '0;
                        byte_cnt <= '0;
                        load_cnt <= '0;
                        aborted  <= 1'b0;
                        state    <= (tx_mode == 2'd3) ? ST_BIST : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (phase_end) begin
                        bit_cnt <= '0;
                        state   <= ST_SOP;
                    end
                end
                ST_SOP: begin
                    if (phase_end) begin
                        bit_cnt <= '0;
                        if (mode_q != 2'd0) begin
                            state <= ST_WAIT;
                        end else if (txdr_vld) begin
                            // First byte is fetched while the ordered set finishes.
                            txfifo_ld <= 1'b1;
                            load_cnt  <= load_cnt + PAY_ONE;
                            state     <= ST_DATA;
                        end else begin
                            tx_abort <= 1'b1;
                            aborted  <= 1'b1;
                            state    <= ST_EOP;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (byte_bit == 4'd9) begin
                            byte_bit <= '0;
                            if (last_byte) begin
                                bit_cnt <= '0;
                                state   <= ST_CRC;
                            end else if (txdr_vld) begin
                                byte_cnt  <= byte_cnt + PAY_ONE;
                                txfifo_ld <= 1'b1;
                                load_cnt  <= load_cnt + PAY_ONE;
                            end else begin
                                // Underrun: CRC would cover missing data, go straight to EOP.
                                bit_cnt  <= '0;
                                tx_abort <= 1'b1;
                                aborted  <= 1'b1;
                                state    <= ST_EOP;
                            end
                        end else begin
                            byte_bit <= byte_bit + 4'd1;
                        end
                    end
                end
                ST_CRC: begin
                    if (phase_end) begin
                        bit_cnt <= '0;
                        state   <= ST_EOP;
                    end
                end
                ST_EOP: begin
                    if (phase_end) begin
                        bit_cnt <= '0;
                        state   <= ST_WAIT;
                    end
                end
                ST_BIST: begin
                    if (phase_end) begin
                        bit_cnt <= '0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (phase_end) begin
                        bit_cnt <= '0;
                        tx_done <= ~aborted;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_state = state;
    assign pre_en   = (state == ST_PRE);
    assign sop_en   = (state == ST_SOP);
    assign data_en  = (state == ST_DATA);
    assign crc_en   = (state == ST_CRC);
    assign eop_en   = (state == ST_EOP);
    assign bist_en  = (state == ST_BIST);
    assign wait_en  = (state == ST_WAIT);
    assign bmc_en   = (state != ST_IDLE);
    assign busy     = bmc_en;
    assign txdr_req = (sop_en | data_en) & (load_cnt < pay_q);

endmodule

// File: tb/tb_apb_ucpd_tx_seq.sv
// Testbench for apb_ucpd_tx_seq: frame-schedule reference model, table of frames, hand-written disable/reset cases.
module tb_apb_ucpd_tx_seq;

    localparam int PRE = 64;
    localparam int SOP = 20;
    localparam int CRC = 40;
    localparam int EOP = 5;
    localparam int PAY_W = 10;
    localparam int IFG_W = 8;

    logic             ic_clk = 1'b0;
    logic             ic_rst_n = 1'b0;
    logic             ucpden = 1'b0;
    logic             bit_tick = 1'b0;
    logic             tx_req = 1'b0;
    logic [1:0]       tx_mode = '0;
    logic [PAY_W-1:0] tx_paysize = '0;
    logic [15:0]      bist_len = '0;
    logic [IFG_W-1:0] ifg_bits = '0;
    logic             txdr_vld = 1'b0;
    logic             txdr_req, txfifo_ld;
    logic [2:0]       tx_state;
    logic             pre_en, sop_en, data_en, crc_en, eop_en, bist_en, wait_en;
    logic             bmc_en, busy, tx_done, tx_abort;

    apb_ucpd_tx_seq dut (
        .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden), .bit_tick(bit_tick),
        .tx_req(tx_req), .tx_mode(tx_mode), .tx_paysize(tx_paysize), .bist_len(bist_len),
        .ifg_bits(ifg_bits), .txdr_vld(txdr_vld), .txdr_req(txdr_req), .txfifo_ld(txfifo_ld),
        .tx_state(tx_state), .pre_en(pre_en), .sop_en(sop_en), .data_en(data_en),
        .crc_en(crc_en), .eop_en(eop_en), .bist_en(bist_en), .wait_en(wait_en),
        .bmc_en(bmc_en), .busy(busy), .tx_done(tx_done), .tx_abort(tx_abort)
    );

    always #5 ic_clk = ~ic_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference frame: ordered list of (state, length in ticks) segments.
    int sg_st[8];
    int sg_len[8];
    int sg_n;
    int m_total, m_pay, m_k, m_mode;

    function automatic void add_seg(input int st, input int len);
        sg_st[sg_n]  = st;
        sg_len[sg_n] = len;
        sg_n++;
        m_total += len;
    endfunction

    // State occupied after n ticks of the frame have been consumed.
    function automatic int m_state(input int n);
        int acc = 0;
        for (int i = 0; i < sg_n; i++) begin
            acc += sg_len[i];
            if (n < acc) return sg_st[i];
        end
        return 0;
    endfunction

    // Bytes loaded after n ticks: load j happens after PRE+SOP+10*j ticks.
    function automatic int m_loads(input int n);
        int c;
        if (m_mode != 0 || n < PRE + SOP) return 0;
        c = (n - PRE - SOP) / 10 + 1;
        return (c < m_k) ? c : m_k;
    endfunction

    function automatic int obs();
        return int'({tx_state, pre_en, sop_en, data_en, crc_en, eop_en, bist_en, wait_en,
                     bmc_en, busy, txdr_req, txfifo_ld, tx_abort, tx_done});
    endfunction

    function automatic int expv(input int es, input bit req, input bit ld, input bit ab, input bit dn);
        logic [2:0] s;
        s = es[2:0];
        return int'({s, es == 1, es == 2, es == 3, es == 4, es == 5, es == 6, es == 7,
                     es != 0, es != 0, req, ld, ab, dn});
    endfunction

    // Runs one frame from IDLE; uk >= 0 makes load number uk (0-based) underrun.
    task automatic run_frame(input string nm, input int mode, input int pay, input int bl,
                             input int ifg, input int uk, output int ticks, output int lds,
                             output int dns, output int abts);
        int pe, be, n, prev, es;
        bit started, fin, req, ld, ab, dn;
        pe = (pay == 0) ? 1 : pay;
        be = (bl == 0) ? 1 : bl;
        m_mode = mode; m_pay = pe; m_k = (uk < 0) ? pe : uk;
        sg_n = 0; m_total = 0;
        if (mode == 3) begin
            add_seg(6, be);
        end else begin
            add_seg(1, PRE);
            add_seg(2, SOP);
            if (mode == 0) begin
                if (uk < 0) begin
                    add_seg(3, 10 * pe); add_seg(4, CRC); add_seg(5, EOP);
                end else begin
                    if (uk > 0) add_seg(3, 10 * uk);
                    add_seg(5, EOP);
                end
            end
        end
        add_seg(7, ifg + 1);

        tx_mode = mode[1:0]; tx_paysize = pay[PAY_W-1:0]; bist_len = bl[15:0];
        ifg_bits = ifg[IFG_W-1:0]; tx_req = 1'b1;
        n = 0; started = 0; fin = 0; lds = 0; dns = 0; abts = 0;
        for (int cyc = 0; cyc < 40000 && !fin; cyc++) begin
            bit_tick = ($urandom_range(0, 3) != 0);
            txdr_vld = !(started && uk >= 0 && m_loads(n) >= uk);
            @(posedge ic_clk); #1;
            prev = n;
            if (bit_tick) begin
                if (started) n++;
                else started = 1;
            end
            if (started) begin
                // Request and geometry must be ignored once the frame is running.
                tx_req = 1'b0;
                tx_mode = 2'($urandom); tx_paysize = PAY_W'($urandom);
                bist_len = 16'($urandom); ifg_bits = IFG_W'($urandom);
            end
            es  = started ? m_state(n) : 0;
            req = (es == 2 || es == 3) && (m_loads(n) < m_pay);
            ld  = (n != prev) && (m_loads(n) > m_loads(prev));
            ab  = (n != prev) && mode == 0 && uk >= 0 && n == PRE + SOP + 10 * uk;
            dn  = (n != prev) && uk < 0 && n == m_total;
            check({nm, "_cycle"}, obs(), expv(es, req, ld, ab, dn));
            lds += int'(txfifo_ld); dns += int'(tx_done); abts += int'(tx_abort);
            if (started && n == m_total) fin = 1;
        end
        check({nm, "_completed"}, int'(fin), 1);
        ticks = n;
    endtask

    typedef struct {
        string nm;
        int mode, pay, bl, ifg, uk;
        int e_ticks, e_lds, e_dns, e_abs;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, l, d, a, pe, uk, md;

        tbl[0] = '{"msg_pay2",   0, 2,    0,   3, -1, 153,   2,    1, 0};
        tbl[1] = '{"hard_rst",   1, 5,    0,   3, -1, 88,    0,    1, 0};
        tbl[2] = '{"bist100",    3, 2,    100, 3, -1, 104,   0,    1, 0};
        tbl[3] = '{"underrun3",  0, 4,    0,   3, 2,  113,   2,    0, 1};
        tbl[4] = '{"cable_rst",  2, 0,    0,   0, -1, 85,    0,    1, 0};
        tbl[5] = '{"pay0",       0, 0,    0,   0, -1, 140,   1,    1, 0};
        tbl[6] = '{"bist0",      3, 0,    0,   0, -1, 2,     0,    1, 0};
        tbl[7] = '{"underrun0",  0, 3,    0,   2, 0,  92,    0,    0, 1};
        tbl[8] = '{"pay_max",    0, 1023, 0,   0, -1, 10360, 1023, 1, 0};
        tbl[9] = '{"ifg_max",    1, 1,    0, 255, -1, 340,   0,    1, 0};

        // Reset state, with stimulus toggling underneath.
        ucpden = 1'b1; tx_req = 1'b1; bit_tick = 1'b1; txdr_vld = 1'b1;
        repeat (3) @(posedge ic_clk);
        #1 check("reset_outputs", obs(), 0);
        tx_req = 1'b0;
        @(negedge ic_clk);
        ic_rst_n = 1'b1;
        @(posedge ic_clk); #1;
        check("idle_after_reset", obs(), 0);

        foreach (tbl[i]) begin
            run_frame(tbl[i].nm, tbl[i].mode, tbl[i].pay, tbl[i].bl, tbl[i].ifg, tbl[i].uk, t, l, d, a);
            check({tbl[i].nm, "_ticks"}, t, tbl[i].e_ticks);
            check({tbl[i].nm, "_loads"}, l, tbl[i].e_lds);
            check({tbl[i].nm, "_done"},  d, tbl[i].e_dns);
            check({tbl[i].nm, "_abort"}, a, tbl[i].e_abs);
        end

        // Randomized frames against the reference model.
        for (int r = 0; r < 12; r++) begin
            md = $urandom_range(0, 3);
            pe = $urandom_range(0, 8);
            uk = -1;
            if (md == 0 && $urandom_range(0, 2) == 0)
                uk = $urandom_range(0, ((pe == 0) ? 1 : pe) - 1);
            run_frame("rand", md, pe, $urandom_range(0, 40), $urandom_range(0, 12), uk, t, l, d, a);
            check("rand_done", d, (uk < 0) ? 1 : 0);
            check("rand_abort", a, (uk < 0) ? 0 : 1);
        end

        // ucpden dropped during CRC.
        tx_mode = 2'd0; tx_paysize = 10'd1; ifg_bits = '0; tx_req = 1'b1; txdr_vld = 1'b1;
        bit_tick = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(posedge ic_clk); #1;
            tx_req = 1'b0;
            if (tx_state == 3'd4) break;
        end
        check("reach_crc", int'(tx_state), 4);
        ucpden = 1'b0;
        @(posedge ic_clk); #1;
        check("disable_clear", obs(), 0);
        ucpden = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge ic_clk); #1;
            check("disable_stays_idle", obs(), 0);
        end
        run_frame("after_disable", 0, 2, 0, 3, -1, t, l, d, a);
        check("after_disable_ticks", t, 153);
        check("after_disable_done", d, 1);

        // Asynchronous reset during DATA.
        tx_mode = 2'd0; tx_paysize = 10'd3; ifg_bits = 8'd1; tx_req = 1'b1; txdr_vld = 1'b1;
        bit_tick = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(posedge ic_clk); #1;
            tx_req = 1'b0;
            if (tx_state == 3'd3) break;
        end
        check("reach_data", int'(tx_state), 3);
        repeat (5) @(posedge ic_clk);
        #3 ic_rst_n = 1'b0;
        #1 check("async_reset_outputs", obs(), 0);
        @(negedge ic_clk);
        ic_rst_n = 1'b1;
        run_frame("after_reset", 0, 1, 0, 0, -1, t, l, d, a);
        check("after_reset_ticks", t, 140);
        check("after_reset_loads", l, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
